// File: rtl/mem_access_initiator.sv
// mem_access_initiator: load/store initiator between the MEM stage and the
// 512-byte big-endian data RAM.
//
// One command at a time is taken on the req_* valid/ready handshake.
// Its size and address alignment are checked: byte is always legal,
// halfword needs addr[0]=0, word needs addr[1:0]=00, and size 11 is illegal.
// A faulting command goes straight to the response and never touches
// the RAM. A legal command runs the RAM port as follows:
//   SETUP   : mem_* driven from the command, mem_enable low
//   ACCESS  : mem_enable high for ACCESS_CYCLES cycles
//   CAPTURE : mem_enable low, load data registered
//   RESP    : response held until resp_ready
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        command handshake
//   req_write                  1 = store, 0 = load
//   req_size                   00 byte, 01 half, 10 word, 11 illegal
//   req_signed                 sign-extend a byte/half load
//   req_addr, req_wdata        byte address, right-justified store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata                 load data (0 for stores and faults)
//   resp_fault                 misaligned address or illegal size
//   mem_enable                 RAM Enable (RAM acts on its rising edge)
//   mem_read_write             RAM ReadWrite, 1 = write
//   mem_address                RAM Address
//   mem_data_in                RAM DataIn
//   mem_size                   RAM Size
//   mem_sign_extend            RAM SignExtend, {1'b0, signed}
//   mem_data_out               RAM DataOut

module mem_access_initiator #(
    parameter int ADDR_W        = 9,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,

    output logic              mem_enable,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic [1:0]        mem_size,
    output logic [1:0]        mem_sign_extend,
    input  logic [31:0]       mem_data_out
);

    // Down-counter wide enough for ACCESS_CYCLES-1.
    localparam int CNT_W =
        (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [CNT_W-1:0]  r_cnt;

    // Latched command; these registers drive the RAM port directly,
    // so they only change on a legal accept and otherwise hold.
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              r_enable;
    logic              r_resp_valid;
    logic [31:0]       r_rdata;
    logic              r_fault;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_fault;
    logic              w_cnt_zero;
    logic              w_resp_done;

    // Alignment / size check on the incoming command.
    always_comb begin
        w_fault = 1'b0;
        unique case (req_size)
            2'b00:   w_fault = 1'b0;
            2'b01:   w_fault = req_addr[0];
            2'b10:   w_fault = |req_addr[1:0];
            default: w_fault = 1'b1;
        endcase
    end

    assign w_accept    = req_valid && w_req_ready;
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_resp_done = r_resp_valid && resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_fault ? S_RESP : S_SETUP;
                end
            end
            S_SETUP: begin
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_cnt_zero) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Enable length counter: loaded in SETUP, counts down in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == S_ACCESS && !w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Command latch / RAM port drivers. A faulting command never
    // disturbs the RAM-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept && !w_fault) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // Registered enable so the RAM sees a clean pulse; it rises
    // exactly once per legal command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= 1'b0;
        end else begin
            r_enable <= (w_next == S_ACCESS);
        end
    end

    // Response path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_resp_valid <= (w_next == S_RESP);
            if (w_accept) begin
                r_rdata <= '0;
                r_fault <= w_fault;
            end else if (r_state == S_CAPTURE) begin
                r_rdata <= r_write ? 32'h0 : mem_data_out;
            end else if (w_resp_done) begin
                r_rdata <= '0;
                r_fault <= 1'b0;
            end
        end
    end

    assign req_ready       = w_req_ready;
    assign resp_valid      = r_resp_valid;
    assign resp_rdata      = r_rdata;
    assign resp_fault      = r_fault;

    assign mem_enable      = r_enable;
    assign mem_read_write  = r_write;
    assign mem_address     = r_addr;
    assign mem_data_in     = r_wdata;
    assign mem_size        = r_size;
    assign mem_sign_extend = {1'b0, r_signed};

endmodule

// File: tb/tb_mem_access_initiator.sv
// tb_mem_access_initiator: two initiators (ACCESS_CYCLES 2 and 1), each on
// its own behavioural big-endian RAM, checked against a command-level model.

module tb_mem_access_initiator;

    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst_n;

    logic          req_valid       [2];
    logic          req_ready       [2];
    logic          req_write       [2];
    logic [1:0]    req_size        [2];
    logic          req_signed      [2];
    logic [AW-1:0] req_addr        [2];
    logic [31:0]   req_wdata       [2];
    logic          resp_valid      [2];
    logic          resp_ready      [2];
    logic [31:0]   resp_rdata      [2];
    logic          resp_fault      [2];
    logic          mem_enable      [2];
    logic          mem_read_write  [2];
    logic [AW-1:0] mem_address     [2];
    logic [31:0]   mem_data_in     [2];
    logic [1:0]    mem_size        [2];
    logic [1:0]    mem_sign_extend [2];
    logic [31:0]   mem_data_out    [2];

    logic [7:0] ram   [2][512];
    logic [7:0] model [2][512];
    logic       prev_en [2] = '{1'b0, 1'b0};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_initiator #(.ADDR_W(AW), .ACCESS_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_size(req_size[0]),
        .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
        .mem_enable(mem_enable[0]), .mem_read_write(mem_read_write[0]),
        .mem_address(mem_address[0]), .mem_data_in(mem_data_in[0]),
        .mem_size(mem_size[0]), .mem_sign_extend(mem_sign_extend[0]),
        .mem_data_out(mem_data_out[0])
    );

    mem_access_initiator #(.ADDR_W(AW), .ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_size(req_size[1]),
        .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
        .mem_enable(mem_enable[1]), .mem_read_write(mem_read_write[1]),
        .mem_address(mem_address[1]), .mem_data_in(mem_data_in[1]),
        .mem_size(mem_size[1]), .mem_sign_extend(mem_sign_extend[1]),
        .mem_data_out(mem_data_out[1])
    );

    // Behavioural RAM: acts once on each rising edge of Enable.
    function automatic logic [31:0] ram_read(input int k);
        int          n;
        logic [31:0] v;
        n = (mem_size[k] == 2'b00) ? 1 : (mem_size[k] == 2'b01) ? 2 : 4;
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = (v << 8) | 32'(ram[k][(int'(mem_address[k]) + i) % 512]);
        if (mem_sign_extend[k][0] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (mem_sign_extend[k][0] && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_enable[k] === 1'b1 && !prev_en[k]) begin
                if (mem_read_write[k]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (i < ((mem_size[k] == 2'b00) ? 1 :
                                 (mem_size[k] == 2'b01) ? 2 : 4))
                            ram[k][(int'(mem_address[k]) + i) % 512] =
                                8'(mem_data_in[k] >> (8 * (((mem_size[k] == 2'b00) ? 1 :
                                   (mem_size[k] == 2'b01) ? 2 : 4) - 1 - i)));
                    end
                end else begin
                    mem_data_out[k] = ram_read(k);
                end
            end
            prev_en[k] <= (mem_enable[k] === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One command end to end; the model decides fault, data and timing.
    task automatic do_cmd(input int k, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [AW-1:0] a,
                          input logic [31:0] wd, input int hold);
        logic          flt;
        logic [31:0]   exp_d;
        longint        v;
        int            n, lat, en_hi, rises, ac;
        logic          prev;
        logic [AW-1:0] a_before;

        ac  = (k == 0) ? 2 : 1;
        flt = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
              (sz == 2'b10 && a[1:0] != 2'b00);
        n     = 1 << int'(sz);
        exp_d = 32'h0;
        if (!flt) begin
            if (wr) begin
                for (int i = 0; i < n; i++)
                    model[k][int'(a) + i] = wd[8 * (n - 1 - i) +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++)
                    v = v * 256 + longint'(model[k][int'(a) + i]);
                if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                    v = v - (longint'(1) << (8 * n));
                exp_d = 32'(v);
            end
        end

        a_before      = mem_address[k];
        req_valid[k]  = 1'b1;
        req_write[k]  = wr;
        req_size[k]   = sz;
        req_signed[k] = sg;
        req_addr[k]   = a;
        req_wdata[k]  = wd;
        resp_ready[k] = (hold == 0);
        check("req_ready", 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;

        lat = 1; en_hi = 0; rises = 0; prev = 1'b0;
        while (resp_valid[k] !== 1'b1 && lat < 40) begin
            if (mem_enable[k] === 1'b1) begin
                en_hi++;
                if (!prev) rises++;
                check("en_addr", 32'(mem_address[k]), 32'(a));
                check("en_rw", 32'(mem_read_write[k]), 32'(wr));
                check("en_size", 32'(mem_size[k]), 32'(sz));
                check("en_sext", 32'(mem_sign_extend[k]), {30'b0, 1'b0, sg});
                if (wr) check("en_din", mem_data_in[k], wd);
            end
            prev = (mem_enable[k] === 1'b1);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(flt ? 1 : ac + 3));
        check("en_cycles", 32'(en_hi), 32'(flt ? 0 : ac));
        check("en_rises", 32'(rises), 32'(flt ? 0 : 1));
        check("fault", 32'(resp_fault[k]), 32'(flt));
        check("rdata", resp_rdata[k], exp_d);
        if (flt) check("addr_kept", 32'(mem_address[k]), 32'(a_before));

        for (int i = 0; i < hold; i++) begin
            req_valid[k] = 1'b1;
            req_addr[k]  = AW'($urandom);
            check("hold_valid", 32'(resp_valid[k]), 32'd1);
            check("hold_rdata", resp_rdata[k], exp_d);
            check("hold_fault", 32'(resp_fault[k]), 32'(flt));
            check("hold_nrdy", 32'(req_ready[k]), 32'd0);
            @(negedge clk);
        end
        req_valid[k]  = 1'b0;
        resp_ready[k] = 1'b1;
        if (hold > 0) check("pre_hs_valid", 32'(resp_valid[k]), 32'd1);
        @(negedge clk);
        check("post_valid", 32'(resp_valid[k]), 32'd0);
        check("post_ready", 32'(req_ready[k]), 32'd1);
        check("post_en", 32'(mem_enable[k]), 32'd0);
    endtask

    initial begin
        logic          wr, sg;
        logic [1:0]    sz;
        logic [AW-1:0] a;
        int            k, hold;

        rst_n = 1'b0;
        for (int j = 0; j < 2; j++) begin
            req_valid[j]    = 1'b0;
            req_write[j]    = 1'b0;
            req_size[j]     = 2'b00;
            req_signed[j]   = 1'b0;
            req_addr[j]     = '0;
            req_wdata[j]    = '0;
            resp_ready[j]   = 1'b0;
            mem_data_out[j] = '0;
            for (int i = 0; i < 512; i++) begin
                ram[j][i]   = 8'($urandom);
                model[j][i] = ram[j][i];
            end
        end

        repeat (2) @(negedge clk);
        check("rst_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_en", 32'(mem_enable[0]), 32'd0);
        check("rst_rdata", resp_rdata[0], 32'd0);
        check("rst_fault", 32'(resp_fault[0]), 32'd0);
        check("rst_addr", 32'(mem_address[0]), 32'd0);
        check("rst_rw", 32'(mem_read_write[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready[0]), 32'd1);

        do_cmd(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 0);
        do_cmd(0, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 0);
        do_cmd(0, 1'b1, 2'b00, 1'b0, 9'h021, 32'h00000080, 0);
        do_cmd(0, 1'b0, 2'b00, 1'b1, 9'h021, 32'h0, 0);
        do_cmd(0, 1'b0, 2'b00, 1'b0, 9'h021, 32'h0, 0);
        do_cmd(0, 1'b0, 2'b01, 1'b0, 9'h033, 32'h0, 0);
        do_cmd(0, 1'b1, 2'b10, 1'b0, 9'h042, 32'h11223344, 0);
        do_cmd(0, 1'b0, 2'b11, 1'b0, 9'h040, 32'h0, 0);
        do_cmd(0, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 4);

        // Reset during the second enable cycle of a load.
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b0;
        req_size[0]   = 2'b10;
        req_signed[0] = 1'b0;
        req_addr[0]   = 9'h100;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_en", 32'(mem_enable[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_en", 32'(mem_enable[0]), 32'd0);
        check("arst_valid", 32'(resp_valid[0]), 32'd0);
        check("arst_addr", 32'(mem_address[0]), 32'd0);
        check("arst_rw", 32'(mem_read_write[0]), 32'd0);
        check("arst_size", 32'(mem_size[0]), 32'd0);
        check("arst_sext", 32'(mem_sign_extend[0]), 32'd0);
        check("arst_din", mem_data_in[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready", 32'(req_ready[0]), 32'd1);
        do_cmd(0, 1'b0, 2'b10, 1'b0, 9'h100, 32'h0, 0);

        do_cmd(1, 1'b1, 2'b10, 1'b0, 9'h1FC, 32'h12345678, 0);
        do_cmd(1, 1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0, 0);

        for (int t = 0; t < 200; t++) begin
            k  = int'($urandom_range(0, 1));
            wr = 1'($urandom);
            sg = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = AW'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_cmd(k, wr, sz, sg, a, $urandom, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
